// File: rtl/scan_mux_pkg.sv
// Shared encodings for the scan_mux block: mode select and sequencer state.
package scan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/next_channel_finder.sv
// Combinational search for the lowest enabled channel strictly above cur.
// cur is signed, so driving all ones (-1) returns the lowest enabled channel.
module next_channel_finder #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [SEL_W:0]      cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                found
);

  // Scanning downward lets the lowest qualifying channel win.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'($signed(cur)))) begin
        nxt   = k[SEL_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 mux with valid/ready output and a one-shot channel sweep.
// The output register only loads when the slot is empty or being drained.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          address,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       enable_mask,
  input  logic                      start,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy
);

  logic [WIDTH-1:0] ch [CHANNELS];
  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch[k] = in[k*WIDTH +: WIDTH];
  end

  state_e              state, state_nxt;
  logic [SEL_W-1:0]    ptr;
  logic [CHANNELS-1:0] mask_q;
  logic [SEL_W-1:0]    first_idx, next_idx;
  logic                first_found, next_found;
  logic                free, start_ok;
  logic                load, load_last;
  logic [WIDTH-1:0]    load_data;
  logic [SEL_W-1:0]    load_addr;

  next_channel_finder #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_first (
    .mask (enable_mask),
    .cur  ('1),
    .nxt  (first_idx),
    .found(first_found)
  );

  next_channel_finder #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_next (
    .mask (mask_q),
    .cur  ({1'b0, ptr}),
    .nxt  (next_idx),
    .found(next_found)
  );

  assign free     = !out_valid || out_ready;
  assign start_ok = (state == IDLE) && (mode == MODE_SCAN) && start && first_found;
  assign busy     = (state == SCAN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SCAN;
      SCAN:    if (free && !next_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_addr = ptr;
    load_last = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_DIRECT && free) begin
          load      = 1'b1;
          load_addr = address;
          load_data = (int'(address) < CHANNELS) ? ch[address] : '0;
        end
      end
      SCAN: begin
        if (free) begin
          load      = 1'b1;
          load_data = ch[ptr];
          load_last = !next_found;
        end
      end
      default: ;
    endcase
  end

  // Mask is captured at start so mid-sweep changes cannot reorder the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      mask_q <= '0;
    end else if (start_ok) begin
      ptr    <= first_idx;
      mask_q <= enable_mask;
    end else if (state == SCAN && free && next_found) begin
      ptr    <= next_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= load_data;
      out_addr  <= load_addr;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output port and an automatic channel-scan sequencer. Successor to the structural 8:1 single-bit mux: the same address-selected path, generalised in width and channel count, plus output registering, backpressure, a channel-enable mask and a one-shot sweep mode. It sits between parallel data sources and a single serial consumer.

## Interface
- `WIDTH`, 1: bits per channel
- `CHANNELS`, 8: number of input channels (≥2)
- `SEL_W`, `$clog2(CHANNELS)`: address width (3 at default)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `in` in CHANNELS*WIDTH: flattened inputs; channel k at `in[k*WIDTH +: WIDTH]`
- `address` in SEL_W: channel select, direct mode
- `mode` in 1: 0 = direct, 1 = scan
- `enable_mask` in CHANNELS: bit k set = channel k included in a sweep
- `start` in 1: one-cycle pulse, launches a sweep (scan mode)
- `out` out WIDTH: registered selected data
- `out_addr` out SEL_W: channel index that `out` came from
- `out_valid` out 1: `out`/`out_addr`/`out_last` hold a transfer
- `out_ready` in 1: consumer accepts when high with `out_valid`
- `out_last` out 1: final channel of a sweep (always 0 in direct mode)
- `busy` out 1: sweep in progress

## Operation
- Output slot is free when `out_valid`=0 or (`out_valid` & `out_ready`); a load happens only when free.
- FSM states: IDLE, SCAN.
- IDLE, `mode`=0: every free cycle, load `out`=in[address], `out_addr`=address, `out_last`=0, `out_valid`=1. `address` ≥ CHANNELS loads `out`=0 with that `out_addr`.
- IDLE, `mode`=1: no loads; free slot drains (`out_valid`→0 after acceptance).
- IDLE, `mode`=1, `start`=1, `enable_mask`≠0 → SCAN; pointer = lowest set mask bit; `busy`=1 the following cycle. `start` with mask=0 ignored.
- SCAN: each free cycle load channel at pointer; `out_last`=1 if no higher enabled channel; pointer advances to next higher enabled channel. After loading the last channel → IDLE, `busy`=0 next cycle (last transfer may still be pending).
- `enable_mask` sampled once at `start`; changes during SCAN ignored. `mode`, `address`, `start` ignored during SCAN.
- While `out_valid`=1 and `out_ready`=0: `out`, `out_addr`, `out_last` held stable; no input resampling.

## Timing
- Latency: input/address to `out` = 1 cycle (registered); throughput 1 transfer/cycle with `out_ready` held high.
- Sweep of E enabled channels, no stalls: `start` at cycle 0 → loads at cycles 1..E; `busy` high cycles 1..E.
- Start-to-start: a new `start` is accepted the cycle after `busy` falls.
- Reset values: `out`=0, `out_addr`=0, `out_valid`=0, `out_last`=0, `busy`=0, state IDLE, pointer 0.
- Reset mid-sweep or with a pending transfer: aborts sweep, drops transfer, all outputs to reset values next edge; `reset` wins over `start`.
- Data values X/Z on inputs pass through unchanged; no masking.

## Structure
- Package `scan_mux_pkg`: mode encoding (`MODE_DIRECT`=0, `MODE_SCAN`=1), FSM state typedef/encoding (IDLE=0, SCAN=1).
- Sub-module `next_channel_finder` (combinational): inputs latched mask and current index; outputs next higher enabled index and a `found` flag; same unit with index = −1 gives the lowest enabled channel.
- Top holds FSM, pointer, latched mask and output register.

## Test plan
- Direct, CHANNELS=8, WIDTH=1, `out_ready`=1: in=8'b1010_0101, address 0..7 → `out` one cycle later = 1,0,1,0,0,1,0,1 with matching `out_addr`.
- Backpressure: direct, WIDTH=8, address=2, in[2]=8'h5A, `out_ready`=0 for 3 cycles while in[2]→8'hFF → `out` stays 8'h5A; accepted on ready; next load 8'hFF.
- Sweep: mask=8'b1001_0110, `start` pulse, ready=1 → `out_addr` 1,2,4,7 on consecutive cycles, `out_last` only with 7, `busy` high exactly 4 cycles.
- Mask edge: mask=0 + `start` → no `busy`, no `out_valid`; mask=8'h80 → single transfer, `out_addr`=7, `out_last`=1.
- Reset mid-sweep: mask=8'hFF, assert `reset` after 3rd load with ready=0 → next cycle `out_valid`=0, `busy`=0, `out`=0; new `start` restarts at channel 0.
- Ignored inputs: `start` and `mode`=0 during SCAN → sweep sequence unchanged, no extra transfers.
